// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS-subset controller.
//   - state_t   : FSM state encodings (also visible on the debug state port)
//   - OP_*/FN_* : opcode and R-type func constants
//   - ALU_*, EXT_*, RD_* : datapath select encodings shared with the
//     single-cycle decoder
//   - iclass_t  : one-hot instruction class produced by mc_decode
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0010;
   localparam logic [3:0] ALU_CMP  = 4'b0011;

   localparam logic [3:0] EXT_ZERO = 4'b0000;
   localparam logic [3:0] EXT_SIGN = 4'b0001;
   localparam logic [3:0] EXT_LUI  = 4'b0010;
   localparam logic [3:0] EXT_BR   = 4'b0011;

   localparam logic [1:0] RD_RT    = 2'b00;
   localparam logic [1:0] RD_RD    = 2'b01;
   localparam logic [1:0] RD_RA    = 2'b10;

   // Exactly one field is set for any opcode/func pair; nop catches the rest.
   typedef struct packed {
      logic addu;
      logic subu;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
      logic jr;
      logic nop;
   } iclass_t;

endpackage

// File: rtl/mc_if.sv
// mc_if: controller <-> datapath signal bundle.
//   master modport : the controller (reads IR fields and flags, drives strobes)
//   slave modport  : the datapath (drives IR fields and flags, reads strobes)
// Handshake: mem_read / mem_write are held for the whole MEM state; the data
// memory raises mem_ready in the cycle it accepts the write or presents read
// data, and the controller leaves MEM at that clock edge. mem_ready is ignored
// in every other state.
interface mc_if #(parameter int ST_W = 3);

   logic [5:0]      opcode;
   logic [5:0]      func;
   logic            alu_zero;
   logic            mem_ready;

   logic            pc_write;
   logic            ir_write;
   logic            reg_write;
   logic            mem_write;
   logic            mem_read;
   logic [1:0]      reg_dst;
   logic            mem_to_reg;
   logic            alu_src;
   logic [3:0]      alu_op;
   logic [3:0]      ext_op;
   logic            npc_sel;
   logic            j;
   logic            jal;
   logic            jr;
   logic            instr_done;
   logic            mem_timeout;
   logic [ST_W-1:0] state;

   modport master (
      input  opcode, func, alu_zero, mem_ready,
      output pc_write, ir_write, reg_write, mem_write, mem_read, reg_dst,
             mem_to_reg, alu_src, alu_op, ext_op, npc_sel, j, jal, jr,
             instr_done, mem_timeout, state
   );

   modport slave (
      output opcode, func, alu_zero, mem_ready,
      input  pc_write, ir_write, reg_write, mem_write, mem_read, reg_dst,
             mem_to_reg, alu_src, alu_op, ext_op, npc_sel, j, jal, jr,
             instr_done, mem_timeout, state
   );

endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/func -> one-hot instruction class.
//   opcode, func : IR[31:26], IR[5:0]
//   cls          : one-hot class; unsupported encodings map to nop
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   output iclass_t    cls
);

   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            case (func)
               FN_ADDU: cls.addu = 1'b1;
               FN_SUBU: cls.subu = 1'b1;
               FN_JR:   cls.jr   = 1'b1;
               default: cls.nop  = 1'b1;
            endcase
         end
         OP_ORI:  cls.ori = 1'b1;
         OP_LUI:  cls.lui = 1'b1;
         OP_LW:   cls.lw  = 1'b1;
         OP_SW:   cls.sw  = 1'b1;
         OP_BEQ:  cls.beq = 1'b1;
         OP_J:    cls.j   = 1'b1;
         OP_JAL:  cls.jal = 1'b1;
         default: cls.nop = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mc_if master (IR fields, alu_zero, mem_ready in; PC/IR/GPR/
//                ALU/extender/memory controls, instr_done, mem_timeout and the
//                debug state out)
// Parameters: ST_W (state port width), MAX_WAIT (MEM stall cycles before
// mem_timeout sets; 0 disables).
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int ST_W     = 3,
   parameter int MAX_WAIT = 255
) (
   input logic  clk,
   input logic  reset,
   mc_if.master bus
);

   localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   // The flag is set on the edge that completes the MAX_WAIT-th stalled cycle.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

   state_t           st;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_q;
   iclass_t          cls;

   mc_decode u_decode (
      .opcode (bus.opcode),
      .func   (bus.func),
      .cls    (cls)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= ST_FETCH;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (st)
            ST_FETCH:  st <= ST_DECODE;
            ST_DECODE: st <= cls.nop ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
               if (cls.lw || cls.sw)                           st <= ST_MEM;
               else if (cls.addu || cls.subu || cls.ori || cls.lui) st <= ST_WB;
               else                                            st <= ST_FETCH;
            end
            ST_MEM:    if (bus.mem_ready) st <= cls.lw ? ST_WB : ST_FETCH;
            ST_WB:     st <= ST_FETCH;
            default:   st <= ST_FETCH;
         endcase

         if (st == ST_MEM && !bus.mem_ready) begin
            // Counter saturates once the flag is raised; the FSM keeps waiting.
            if (MAX_WAIT > 0 && wait_cnt == WAIT_LAST) timeout_q <= 1'b1;
            else                                       wait_cnt  <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   always_comb begin
      bus.pc_write    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_read    = 1'b0;
      bus.reg_dst     = RD_RT;
      bus.mem_to_reg  = 1'b0;
      bus.alu_src     = 1'b0;
      bus.alu_op      = ALU_ADD;
      bus.ext_op      = EXT_ZERO;
      bus.npc_sel     = 1'b0;
      bus.j           = 1'b0;
      bus.jal         = 1'b0;
      bus.jr          = 1'b0;
      bus.instr_done  = 1'b0;
      bus.mem_timeout = timeout_q & ~reset;
      bus.state       = reset ? '0 : ST_W'(st);

      if (!reset) begin
         // Operand selects follow the class from DECODE onward so the
         // datapath sees them stable through EXEC/MEM/WB.
         if (st != ST_FETCH) begin
            if (cls.addu || cls.subu) begin
               bus.reg_dst = RD_RD;
               bus.alu_op  = cls.subu ? ALU_SUB : ALU_ADD;
            end
            if (cls.ori) begin
               bus.alu_src = 1'b1;
               bus.ext_op  = EXT_ZERO;
               bus.alu_op  = ALU_OR;
            end
            if (cls.lui) begin
               bus.alu_src = 1'b1;
               bus.ext_op  = EXT_LUI;
            end
            if (cls.lw || cls.sw) begin
               bus.alu_src = 1'b1;
               bus.ext_op  = EXT_SIGN;
            end
            if (cls.beq) begin
               bus.alu_op = ALU_CMP;
               bus.ext_op = EXT_BR;
            end
            if (cls.jal) bus.reg_dst = RD_RA;
         end

         case (st)
            ST_FETCH: begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
            end
            ST_DECODE: bus.instr_done = cls.nop;
            ST_EXEC: begin
               if (cls.beq) begin
                  bus.npc_sel    = 1'b1;
                  bus.pc_write   = bus.alu_zero;
                  bus.instr_done = 1'b1;
               end
               if (cls.j || cls.jal) begin
                  bus.j          = 1'b1;
                  bus.pc_write   = 1'b1;
                  bus.instr_done = 1'b1;
               end
               if (cls.jal) begin
                  bus.jal       = 1'b1;
                  bus.reg_write = 1'b1;
               end
               if (cls.jr) begin
                  bus.jr         = 1'b1;
                  bus.pc_write   = 1'b1;
                  bus.instr_done = 1'b1;
               end
            end
            ST_MEM: begin
               bus.mem_read  = cls.lw;
               bus.mem_write = cls.sw;
               // A store finishes in the MEM cycle the memory accepts it, so
               // its completion pulse is the one output qualified by mem_ready.
               bus.instr_done = cls.sw & bus.mem_ready;
            end
            ST_WB: begin
               bus.reg_write  = 1'b1;
               bus.instr_done = 1'b1;
               bus.mem_to_reg = cls.lw;
               bus.reg_dst    = (cls.addu || cls.subu) ? RD_RD : RD_RT;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl; inputs change and outputs are sampled just after
// the falling clock edge.
module tb_mc_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mc_if #(.ST_W(3)) bus ();

   mc_ctrl #(.ST_W(3), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // {pc_write, ir_write, reg_write, mem_write, mem_read}
   logic [4:0] strobes;
   assign strobes = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.mem_read};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.opcode = 6'b000000;
      bus.func = 6'b000000;
      bus.alu_zero = 1'b0;
      bus.mem_ready = 1'b0;

      // reset
      step(); step(); #1;
      chk("rst_state", 8'(bus.state), 8'd0);
      chk("rst_strobes", 8'(strobes), 8'd0);
      chk("rst_timeout", 8'(bus.mem_timeout), 8'd0);

      // addu, mem_ready high throughout (must be ignored outside MEM)
      reset = 1'b0; bus.opcode = 6'b000000; bus.func = 6'b100001; bus.mem_ready = 1'b1; #1;
      chk("addu_f_state", 8'(bus.state), 8'd0);
      chk("addu_f_strobes", 8'(strobes), 8'b11000);
      step(); #1;
      chk("addu_d_state", 8'(bus.state), 8'd1);
      chk("addu_d_strobes", 8'(strobes), 8'd0);
      step(); #1;
      chk("addu_e_state", 8'(bus.state), 8'd2);
      chk("addu_e_strobes", 8'(strobes), 8'd0);
      chk("addu_e_done", 8'(bus.instr_done), 8'd0);
      step(); #1;
      chk("addu_w_state", 8'(bus.state), 8'd4);
      chk("addu_w_strobes", 8'(strobes), 8'b00100);
      chk("addu_w_regdst", 8'(bus.reg_dst), 8'd1);
      chk("addu_w_done", 8'(bus.instr_done), 8'd1);

      // lw, three stalled MEM cycles then ready
      step(); bus.opcode = 6'b100011; bus.mem_ready = 1'b0; #1;
      chk("lw_f_state", 8'(bus.state), 8'd0);
      step(); #1;
      chk("lw_d_state", 8'(bus.state), 8'd1);
      step(); #1;
      chk("lw_e_state", 8'(bus.state), 8'd2);
      chk("lw_e_alusrc", 8'(bus.alu_src), 8'd1);
      chk("lw_e_extop", 8'(bus.ext_op), 8'd1);
      chk("lw_e_strobes", 8'(strobes), 8'd0);
      for (int i = 1; i <= 3; i++) begin
         step(); #1;
         chk($sformatf("lw_m%0d_state", i), 8'(bus.state), 8'd3);
         chk($sformatf("lw_m%0d_strobes", i), 8'(strobes), 8'b00001);
      end
      step(); bus.mem_ready = 1'b1; #1;
      chk("lw_m4_state", 8'(bus.state), 8'd3);
      chk("lw_m4_strobes", 8'(strobes), 8'b00001);
      chk("lw_m4_done", 8'(bus.instr_done), 8'd0);
      step(); bus.mem_ready = 1'b0; #1;
      chk("lw_w_state", 8'(bus.state), 8'd4);
      chk("lw_w_memtoreg", 8'(bus.mem_to_reg), 8'd1);
      chk("lw_w_regdst", 8'(bus.reg_dst), 8'd0);
      chk("lw_w_strobes", 8'(strobes), 8'b00100);
      chk("lw_w_done", 8'(bus.instr_done), 8'd1);
      chk("lw_w_timeout", 8'(bus.mem_timeout), 8'd0);

      // beq not taken
      step(); bus.opcode = 6'b000100; bus.alu_zero = 1'b0; #1;
      chk("beq0_f_state", 8'(bus.state), 8'd0);
      step(); step(); #1;
      chk("beq0_e_state", 8'(bus.state), 8'd2);
      chk("beq0_e_strobes", 8'(strobes), 8'd0);
      chk("beq0_e_npcsel", 8'(bus.npc_sel), 8'd1);
      chk("beq0_e_aluop", 8'(bus.alu_op), 8'd3);
      chk("beq0_e_extop", 8'(bus.ext_op), 8'd3);
      chk("beq0_e_done", 8'(bus.instr_done), 8'd1);

      // beq taken
      step(); bus.alu_zero = 1'b1; #1;
      chk("beq1_f_state", 8'(bus.state), 8'd0);
      step(); step(); #1;
      chk("beq1_e_state", 8'(bus.state), 8'd2);
      chk("beq1_e_strobes", 8'(strobes), 8'b10000);
      chk("beq1_e_npcsel", 8'(bus.npc_sel), 8'd1);

      // jal
      step(); bus.opcode = 6'b000011; bus.alu_zero = 1'b0; #1;
      chk("jal_f_state", 8'(bus.state), 8'd0);
      step(); step(); #1;
      chk("jal_e_state", 8'(bus.state), 8'd2);
      chk("jal_e_regdst", 8'(bus.reg_dst), 8'd2);
      chk("jal_e_strobes", 8'(strobes), 8'b10100);
      chk("jal_e_jumps", 8'({bus.j, bus.jal, bus.jr}), 8'b110);
      chk("jal_e_done", 8'(bus.instr_done), 8'd1);

      // unknown opcode -> nop
      step(); bus.opcode = 6'b111111; #1;
      chk("nop_f_state", 8'(bus.state), 8'd0);
      step(); #1;
      chk("nop_d_state", 8'(bus.state), 8'd1);
      chk("nop_d_done", 8'(bus.instr_done), 8'd1);
      chk("nop_d_strobes", 8'(strobes), 8'd0);

      // ori
      step(); bus.opcode = 6'b001101; #1;
      chk("ori_f_state", 8'(bus.state), 8'd0);
      step(); step(); #1;
      chk("ori_e_aluop", 8'(bus.alu_op), 8'd2);
      chk("ori_e_ctl", 8'({bus.alu_src, bus.ext_op}), 8'b10000);
      step(); #1;
      chk("ori_w_state", 8'(bus.state), 8'd4);
      chk("ori_w_regdst", 8'(bus.reg_dst), 8'd0);
      chk("ori_w_strobes", 8'(strobes), 8'b00100);

      // sw never acknowledged: timeout after 4 stalled MEM cycles, then reset
      step(); bus.opcode = 6'b101011; bus.mem_ready = 1'b0; #1;
      chk("sw_f_state", 8'(bus.state), 8'd0);
      step(); step(); #1;
      chk("sw_e_strobes", 8'(strobes), 8'd0);
      for (int i = 1; i <= 4; i++) begin
         step(); #1;
         chk($sformatf("sw_m%0d_strobes", i), 8'(strobes), 8'b00010);
         chk($sformatf("sw_m%0d_timeout", i), 8'(bus.mem_timeout), 8'd0);
      end
      step(); #1;
      chk("sw_m5_state", 8'(bus.state), 8'd3);
      chk("sw_m5_timeout", 8'(bus.mem_timeout), 8'd1);
      chk("sw_m5_done", 8'(bus.instr_done), 8'd0);
      step(); #1;
      chk("sw_m6_timeout", 8'(bus.mem_timeout), 8'd1);
      reset = 1'b1; #1;
      chk("sw_rst_strobes", 8'(strobes), 8'd0);
      chk("sw_rst_state", 8'(bus.state), 8'd0);
      step(); reset = 1'b0; #1;
      chk("post_rst_state", 8'(bus.state), 8'd0);
      chk("post_rst_timeout", 8'(bus.mem_timeout), 8'd0);
      chk("post_rst_strobes", 8'(strobes), 8'b11000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
